aes128_inv_round_core: RTL

Round-based AES-128 decryption core, the inverse-cipher counterpart of the team's round-based AES encryption datapath. It accepts a ciphertext block and the final (round-10) round key. It computes one inverse round per clock and rolls the key schedule backwards on the fly. It instantiates 16 inverse S-box lookups for InvSubBytes and 4 forward S-box lookups for the reverse key expansion.

---
 rtl/aes128_inv_round_core_if.sv | 19 +
 rtl/aes128_inv_round_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/aes128_inv_round_core_if.sv
// Handshake and data bundle for the round-based AES-128 decryption core.
interface aes128_inv_round_core_if;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key_last;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    modport master (
        output start, ciphertext, key_last,
        input  busy, done, plaintext
    );

    modport slave (
        input  start, ciphertext, key_last,
        output busy, done, plaintext
    );
endinterface

// File: rtl/aes128_inv_round_core.sv
// Round-based AES-128 inverse cipher: one inverse round per clock,
// round keys rolled backwards from the round-10 key on the fly.
module aes128_inv_round_core (
    input  logic                      clk,
    input  logic                      rst_n,
    aes128_inv_round_core_if.slave    bus
);
    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;
    logic [127:0] rk_nxt;
    logic [127:0] rnd_t;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // a^254 is the field inverse and maps 0 to 0, as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] p;
        s = a;
        p = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] y;
        y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(y);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] =
                    inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a, m2, m4, m8;
        logic [7:0]   e [4];
        logic [7:0]   b [4];
        logic [7:0]   d [4];
        logic [7:0]   n [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a    = s[127-32*c-8*r -: 8];
                m2   = xt(a);
                m4   = xt(m2);
                m8   = xt(m4);
                n[r] = m8 ^ a;
                b[r] = m8 ^ m2 ^ a;
                d[r] = m8 ^ m4 ^ a;
                e[r] = m8 ^ m4 ^ m2;
            end
            o[127-32*c -: 32] = {e[0] ^ b[1] ^ d[2] ^ n[3],
                                 n[0] ^ e[1] ^ b[2] ^ d[3],
                                 d[0] ^ n[1] ^ e[2] ^ b[3],
                                 b[0] ^ d[1] ^ n[2] ^ e[3]};
        end
        return o;
    endfunction

    // w3 is rebuilt first because the previous key's g() depends on it
    function automatic logic [127:0] inv_key_exp(input logic [127:0] k,
                                                 input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, g;
        {w4, w5, w6, w7} = k;
        w3 = w7 ^ w6;
        w2 = w6 ^ w5;
        w1 = w5 ^ w4;
        g  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w4 ^ g ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
        return (rc == 8'h1b) ? 8'h80 : ((rc >> 1) ^ (rc[0] ? 8'h8d : 8'h00));
    endfunction

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        rk_nxt  = inv_key_exp(rk_q, rcon_q);
        rnd_t   = inv_shift_sub(state_q) ^ rk_nxt;
        unique case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.ciphertext ^ bus.key_last;
                    rk_d    = bus.key_last;
                    rnd_d   = 4'd9;
                    rcon_d  = 8'h36;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                rk_d   = rk_nxt;
                rcon_d = rcon_prev(rcon_q);
                if (rnd_q == 4'd0) begin
                    state_d = rnd_t;
                    pt_d    = rnd_t;
                    done_d  = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    state_d = inv_mix(rnd_t);
                    rnd_d   = rnd_q - 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            rcon_q  <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (fsm_q == RUN);
    assign bus.done      = done_q;
    assign bus.plaintext = pt_q;
endmodule
